// File: rtl/krnl_partialknn_local_sp_arbiter.sv
// Round-robin arbiter sharing one single-port local URAM between a writer and a reader,
// with credit-tracked read latency and a FWFT response FIFO. Optional: KNN_LOCAL_SP_ARB_PERF_EN.
module krnl_partialknn_local_sp_arbiter #(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 11,
    parameter int MEM_LATENCY = 1,
    parameter int RESP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_address0,
    output logic                  mem_ce0,
    output logic                  mem_we0,
    output logic [DATA_WIDTH-1:0] mem_d0,
`ifdef KNN_LOCAL_SP_ARB_PERF_EN
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_rd_cnt,
    output logic [31:0]           perf_conflict_cnt,
    output logic [31:0]           perf_credit_stall_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] mem_q0
);

    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + MEM_LATENCY + 1);

    logic [MEM_LATENCY-1:0] infl_q, infl_d;
    logic [DATA_WIDTH-1:0]  fifo_q [RESP_DEPTH];
    logic [PW-1:0]          wptr_q, rptr_q;
    logic [PW:0]            cnt_q, cnt_d;
    logic                   rr_rd_q;

    logic [CW-1:0] outst;
    logic          credit, wr_req, rd_elig;
    logic          gnt_w, gnt_r, push, pop, full;

    // Outstanding reads: tagged in the latency pipe plus held in the FIFO
    always_comb begin
        outst = CW'(cnt_q);
        for (int i = 0; i < MEM_LATENCY; i++) begin
            outst = outst + CW'(infl_q[i]);
        end
    end

    assign credit  = outst < CW'(RESP_DEPTH);
    assign wr_req  = reset && wr_valid;
    assign rd_elig = reset && rd_valid && credit;

    // Reader wins when alone or when it holds the round-robin token
    assign gnt_r = rd_elig && (!wr_req || rr_rd_q);
    assign gnt_w = wr_req && !gnt_r;

    assign wr_ready     = gnt_w;
    assign rd_ready     = gnt_r;
    assign mem_ce0      = gnt_w || gnt_r;
    assign mem_we0      = gnt_w;
    assign mem_address0 = gnt_w ? wr_addr : (gnt_r ? rd_addr : '0);
    assign mem_d0       = gnt_w ? wr_data : '0;

    assign push      = infl_q[MEM_LATENCY-1];
    assign full      = cnt_q == (PW+1)'(RESP_DEPTH);
    assign rsp_valid = reset && (cnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? fifo_q[rptr_q] : '0;

    // Shift the read tag one stage per cycle toward the FIFO push point
    always_comb begin
        infl_d[0] = gnt_r;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            infl_d[i] = infl_q[i-1];
        end
    end

    // Occupancy follows push/pop; simultaneous push and pop cancel
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state: latency tags, FIFO pointers, round-robin token
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            infl_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            rr_rd_q <= 1'b1;
        end else begin
            infl_q <= infl_d;
            cnt_q  <= cnt_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (gnt_w)      rr_rd_q <= 1'b1;
            else if (gnt_r) rr_rd_q <= 1'b0;
        end
    end

    // Response storage captures q0 only when a tagged read lands
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= mem_q0;
    end

    // Credit accounting must make a push into a full FIFO impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && full));

`ifdef KNN_LOCAL_SP_ARB_PERF_EN
    logic [31:0] pwr_q, prd_q, pcf_q, pst_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwr_q <= '0;
            prd_q <= '0;
            pcf_q <= '0;
            pst_q <= '0;
        end else begin
            if (gnt_w && pwr_q != '1) pwr_q <= pwr_q + 32'd1;
            if (gnt_r && prd_q != '1) prd_q <= prd_q + 32'd1;
            if (wr_valid && rd_valid && pcf_q != '1) pcf_q <= pcf_q + 32'd1;
            if (rd_valid && !credit && pst_q != '1) pst_q <= pst_q + 32'd1;
        end
    end

    assign perf_wr_cnt           = pwr_q;
    assign perf_rd_cnt           = prd_q;
    assign perf_conflict_cnt     = pcf_q;
    assign perf_credit_stall_cnt = pst_q;
`endif

endmodule

// File: tb/tb_krnl_partialknn_local_sp_arbiter.sv
// Scoreboard bench for the local SP arbiter with a behavioural 1-cycle URAM.
// Issue monitor queues expected data; response monitor checks the FIFO head.
module tb_krnl_partialknn_local_sp_arbiter;

    localparam int DW = 256;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid = 1'b0, rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid, rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] mem_address0;
    logic          mem_ce0, mem_we0;
    logic [DW-1:0] mem_d0;
    logic [DW-1:0] mem_q0 = '0;

    logic [DW-1:0] tmem [2048];
    logic [DW-1:0] refm [2048];
    logic [DW-1:0] expq [$];

    int n_cmp = 0;
    int n_err = 0;
    int n_rsp = 0;

    always #5 clk = ~clk;

    krnl_partialknn_local_sp_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1), .RESP_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_address0(mem_address0), .mem_ce0(mem_ce0),
        .mem_we0(mem_we0), .mem_d0(mem_d0), .mem_q0(mem_q0)
    );

    function automatic logic [DW-1:0] pat(int a);
        return {8{32'hC0DE_0000 | 32'(a)}};
    endfunction

    task automatic check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural single-port URAM, read latency 1
    always @(posedge clk) begin
        if (mem_ce0) begin
            if (mem_we0) tmem[mem_address0] <= mem_d0;
            else         mem_q0 <= tmem[mem_address0];
        end
    end

    // Issue monitor: record writes, queue expected read data
    always @(negedge clk) begin
        if (wr_ready) refm[wr_addr] = wr_data;
        if (rd_ready) expq.push_back(refm[rd_addr]);
    end

    // Response monitor: compare head every valid cycle, pop on handshake
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got %0h expected none", rsp_data);
            end else begin
                check("rsp_data", rsp_data, expq[0]);
                if (rsp_ready) begin
                    void'(expq.pop_front());
                    n_rsp++;
                end
            end
        end
    end

    task automatic drain(string nm);
        int t;
        t = 0;
        while (expq.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(nm, DW'(expq.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g, k, base, t;
        for (int i = 0; i < 2048; i++) begin
            tmem[i] = pat(i);
            refm[i] = pat(i);
        end

        // Reset held with both requests pending
        wr_valid = 1'b1; rd_valid = 1'b1;
        wr_addr = AW'(7); wr_data = pat(999); rd_addr = AW'(3);
        @(negedge clk);
        @(negedge clk);
        check("reset_outs",
              DW'({wr_ready, rd_ready, rsp_valid, mem_ce0, mem_we0,
                   |mem_address0, |mem_d0, |rsp_data}), '0);

        // Release into a conflict run: R,W,R,W,R,W
        base = n_rsp;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_addr = AW'(100 + i);
            wr_data = {8{32'hA000_0000 + 32'(i)}};
            rd_addr = AW'(10 + i);
            @(negedge clk);
            check("conflict_grant", DW'({wr_ready, rd_ready}),
                  (i % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
            @(posedge clk); #1;
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        drain("conflict_drain");
        check("conflict_rsp_cnt", DW'(n_rsp - base), DW'(3));

        // Write 0xAA.. to addr 5, then read it back
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_addr = AW'(5); wr_data = {32{8'hAA}};
        @(negedge clk);
        check("lat_wr_grant", DW'(wr_ready), DW'(1));
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = AW'(5);
        @(negedge clk);
        check("lat_rd_grant", DW'(rd_ready), DW'(1));
        @(posedge clk); #1;
        rd_valid = 1'b0;
        @(negedge clk);
        check("lat_early", DW'(rsp_valid), DW'(0));
        @(negedge clk);
        check("lat_valid", DW'(rsp_valid), DW'(1));
        check("lat_data", rsp_data, {32{8'hAA}});
        drain("lat_drain");

        // Backpressure: 8 reads offered with the consumer stalled
        base = n_rsp;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        k = 0; g = 0;
        for (int c = 0; c < 12; c++) begin
            rd_valid = (k < 8);
            rd_addr = AW'(200 + k);
            @(negedge clk);
            if (rd_ready) begin k++; g++; end
            @(posedge clk); #1;
        end
        check("bp_grants", DW'(g), DW'(4));
        rsp_ready = 1'b1;
        t = 0;
        while (k < 8 && t < 100) begin
            rd_valid = 1'b1;
            rd_addr = AW'(200 + k);
            @(negedge clk);
            if (rd_ready) k++;
            @(posedge clk); #1;
            t++;
        end
        rd_valid = 1'b0;
        check("bp_all_issued", DW'(k), DW'(8));
        drain("bp_drain");
        check("bp_rsp_cnt", DW'(n_rsp - base), DW'(8));

        // Streaming: 64 back-to-back reads
        base = n_rsp;
        g = 0;
        for (int c = 0; c < 64; c++) begin
            rd_valid = 1'b1;
            rd_addr = AW'(300 + c);
            @(negedge clk);
            if (rd_ready) g++;
            @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        check("stream_grants", DW'(g), DW'(64));
        drain("stream_drain");
        check("stream_rsp_cnt", DW'(n_rsp - base), DW'(64));

        // Reset with reads in flight and FIFO occupied
        rsp_ready = 1'b0;
        k = 0; t = 0;
        while (k < 3 && t < 20) begin
            rd_valid = 1'b1;
            rd_addr = AW'(400 + k);
            @(negedge clk);
            if (rd_ready) k++;
            @(posedge clk); #1;
            t++;
        end
        rd_addr = AW'(400 + k);
        #1;
        reset = 1'b0;
        expq.delete();
        #1;
        check("midrst_rsp_valid", DW'(rsp_valid), DW'(0));
        check("midrst_rd_ready", DW'(rd_ready), DW'(0));
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        rd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("midrst_no_stale", DW'(rsp_valid), DW'(0));
        end
        @(posedge clk); #1;
        base = n_rsp;
        rsp_ready = 1'b0;
        k = 0; g = 0;
        for (int c = 0; c < 12; c++) begin
            rd_valid = (k < 4);
            rd_addr = AW'(500 + k);
            @(negedge clk);
            if (rd_ready) begin k++; g++; end
            @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        check("midrst_credit", DW'(g), DW'(4));
        rsp_ready = 1'b1;
        drain("midrst_drain");
        check("midrst_rsp_cnt", DW'(n_rsp - base), DW'(4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
